// File: rtl/cache_pmem_arbiter.sv
// Arbitrates icache/dcache whole-line requests onto a single 4-beat burst pmem port.
// Optional round-robin arbitration between the caches is enabled by defining ARB_ROUND_ROBIN_EN.
module cache_pmem_arbiter #(
   parameter int S_LINE = 256,
   parameter int S_BEAT = 64,
   parameter int S_ADDR = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [S_ADDR-1:0] i_address,
   output logic [S_LINE-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [S_ADDR-1:0] d_address,
   input  logic [S_LINE-1:0] d_wdata,
   output logic [S_LINE-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [S_ADDR-1:0] pmem_address,
   output logic [S_BEAT-1:0] pmem_wdata,
   input  logic [S_BEAT-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int N_BEATS = S_LINE / S_BEAT;
   localparam int CW      = $clog2(N_BEATS);
   localparam int OFFSET  = $clog2(S_LINE / 8);
   localparam logic [S_ADDR-1:0] OFF_MASK  = S_ADDR'((1 << OFFSET) - 1);
   localparam logic [CW-1:0]     LAST_BEAT = CW'(N_BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, I_READ, D_READ, D_WRITE, DONE_I, DONE_D
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [S_ADDR-1:0] addr_q, addr_d;
   logic [S_LINE-1:0] wbuf_q, wbuf_d;
   logic [S_LINE-1:0] ibuf_q, ibuf_d;
   logic [S_LINE-1:0] dbuf_q, dbuf_d;
   logic              d_req;
   logic              d_wins;

   assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner_q, last_owner_d;   // 0 = icache owned the previous burst, 1 = dcache

   assign d_wins = d_req & (~i_read | ~last_owner_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_owner_q <= 1'b0;
      else      last_owner_q <= last_owner_d;
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_q == IDLE) begin
         if (d_wins)      last_owner_d = 1'b1;
         else if (i_read) last_owner_d = 1'b0;
      end
   end
`else
   assign d_wins = d_req;
`endif

   // NOTE: the line buffers are ordinary registers, not RAM, so they can and do reset to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         ibuf_q  <= '0;
         dbuf_q  <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge value of its peers.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         ibuf_q  <= ibuf_d;
         dbuf_q  <= dbuf_d;
      end
   end

   always_comb begin
      // NOTE: every target gets a hold default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wbuf_d  = wbuf_q;
      ibuf_d  = ibuf_q;
      dbuf_d  = dbuf_q;
      case (state_q)
         IDLE: begin
            if (d_wins) begin
               addr_d = d_address & ~OFF_MASK;
               if (d_write) begin
                  state_d = D_WRITE;
                  wbuf_d  = d_wdata;
               end else begin
                  state_d = D_READ;
               end
            end else if (i_read) begin
               addr_d  = i_address & ~OFF_MASK;
               state_d = I_READ;
            end
         end
         I_READ, D_READ, D_WRITE: begin
            if (pmem_resp) begin
               if (state_q == I_READ) ibuf_d[cnt_q*S_BEAT +: S_BEAT] = pmem_rdata;
               if (state_q == D_READ) dbuf_d[cnt_q*S_BEAT +: S_BEAT] = pmem_rdata;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = (state_q == I_READ) ? DONE_I : DONE_D;
               end
            end
         end
         DONE_I, DONE_D: state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   assign pmem_read    = (state_q == I_READ) || (state_q == D_READ);
   assign pmem_write   = (state_q == D_WRITE);
   assign pmem_address = addr_q;
   assign pmem_wdata   = (state_q == D_WRITE) ? wbuf_q[cnt_q*S_BEAT +: S_BEAT] : '0;
   assign i_resp       = (state_q == DONE_I);
   assign d_resp       = (state_q == DONE_D);
   assign i_rdata      = ibuf_q;
   assign d_rdata      = dbuf_q;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Scoreboard bench for cache_pmem_arbiter (default fixed-priority build).
// A pmem responder model serves bursts; expected lines are queued at request time and checked on resp.
`timescale 1ns/1ps
module tb_cache_pmem_arbiter;
   localparam int S_LINE = 256;
   localparam int S_BEAT = 64;
   localparam int S_ADDR = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_read = 1'b0;
   logic [S_ADDR-1:0] i_address = '0;
   logic [S_LINE-1:0] i_rdata;
   logic              i_resp;
   logic              d_read = 1'b0;
   logic              d_write = 1'b0;
   logic [S_ADDR-1:0] d_address = '0;
   logic [S_LINE-1:0] d_wdata = '0;
   logic [S_LINE-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [S_ADDR-1:0] pmem_address;
   logic [S_BEAT-1:0] pmem_wdata;
   logic [S_BEAT-1:0] pmem_rdata = '0;
   logic              pmem_resp = 1'b0;

   always #5 clk = ~clk;

   cache_pmem_arbiter #(.S_LINE(S_LINE), .S_BEAT(S_BEAT), .S_ADDR(S_ADDR)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   typedef struct {
      logic              is_d;
      logic              chk_line;
      logic [S_LINE-1:0] line;
   } exp_t;

   exp_t  sb_q[$];
   exp_t  mon_e;
   int    total = 0;
   int    bad = 0;
   int    n_i_resp = 0;
   int    n_d_resp = 0;
   string order = "";

   // Scoreboard side: every resp pops the oldest expectation.
   always @(negedge clk) begin
      if (rst && (i_resp || d_resp)) begin
         total++;
         if (i_resp) begin n_i_resp++; order = {order, "I"}; end
         if (d_resp) begin n_d_resp++; order = {order, "D"}; end
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_resp: got i_resp=%0b d_resp=%0b, wanted none", i_resp, d_resp);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.is_d !== d_resp || i_resp === d_resp) begin
               bad++;
               $display("FAIL sb_port: got i_resp=%0b d_resp=%0b, wanted %s", i_resp, d_resp,
                        mon_e.is_d ? "dcache" : "icache");
            end else if (mon_e.chk_line && ((mon_e.is_d ? d_rdata : i_rdata) !== mon_e.line)) begin
               bad++;
               $display("FAIL sb_line: got %h wanted %h", mon_e.is_d ? d_rdata : i_rdata, mon_e.line);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [S_LINE-1:0] mk_line(input logic [3:0] a, b, c, d);
      mk_line = {{16{d}}, {16{c}}, {16{b}}, {16{a}}};
   endfunction

   task automatic push(input logic is_d, input logic chk, input logic [S_LINE-1:0] line);
      exp_t e;
      e.is_d = is_d; e.chk_line = chk; e.line = line;
      sb_q.push_back(e);
   endtask

   task automatic wait_burst(input bit wr, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr ? pmem_write : pmem_read) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL burst_start: got no %s within 20 cycles", wr ? "pmem_write" : "pmem_read");
      end
   endtask

   // Responder: nb beats, gap idle cycles between beats, optional stall before beat stall_at.
   task automatic serve(input bit wr, input logic [S_LINE-1:0] line, input logic [S_ADDR-1:0] addr,
                        input int gap, input int stall_at, input int stall_len, input int nb);
      for (int k = 0; k < nb; k++) begin
         if (k == stall_at) begin
            repeat (stall_len) begin
               @(negedge clk);
               total++;
               if (pmem_read !== !wr || pmem_write !== wr || pmem_address !== addr) begin
                  bad++;
                  $display("FAIL stall_hold: got rd=%0b wr=%0b addr=%h wanted rd=%0b wr=%0b addr=%h",
                           pmem_read, pmem_write, pmem_address, !wr, wr, addr);
               end
            end
         end
         @(negedge clk);
         pmem_rdata = wr ? '0 : line[k*S_BEAT +: S_BEAT];
         pmem_resp  = 1'b1;
         #1;
         total++;
         if (pmem_address !== addr || pmem_read !== !wr || pmem_write !== wr) begin
            bad++;
            $display("FAIL beat%0d_ctrl: got rd=%0b wr=%0b addr=%h wanted rd=%0b wr=%0b addr=%h",
                     k, pmem_read, pmem_write, pmem_address, !wr, wr, addr);
         end
         total++;
         if (pmem_wdata !== (wr ? line[k*S_BEAT +: S_BEAT] : '0)) begin
            bad++;
            $display("FAIL beat%0d_wdata: got %h wanted %h", k, pmem_wdata,
                     wr ? line[k*S_BEAT +: S_BEAT] : '0);
         end
         @(posedge clk); #1;
         pmem_resp  = 1'b0;
         pmem_rdata = '0;
         if (k < nb - 1) repeat (gap) @(posedge clk);
      end
   endtask

   task automatic finish_burst(input bit is_d, input bit drop_req);
      @(negedge clk);
      total++;
      if ((is_d ? d_resp : i_resp) !== 1'b1 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         bad++;
         $display("FAIL resp_cycle: got i_resp=%0b d_resp=%0b rd=%0b wr=%0b wanted %s resp and pmem idle",
                  i_resp, d_resp, pmem_read, pmem_write, is_d ? "d" : "i");
      end
      @(posedge clk); #1;
      if (drop_req) begin
         if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
         else i_read = 1'b0;
      end
      @(negedge clk);
      total++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
         bad++;
         $display("FAIL resp_width: got i_resp=%0b d_resp=%0b wanted 0 0", i_resp, d_resp);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got i_resp=%0b d_resp=%0b rd=%0b wr=%0b addr=%h, wanted all 0",
                  i_resp, d_resp, pmem_read, pmem_write, pmem_address);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_icache_read();
      logic [S_LINE-1:0] line;
      bit ok;
      line = mk_line(4'h1, 4'h2, 4'h3, 4'h4);
      i_read = 1'b1; i_address = 32'h0000_1064;
      push(1'b0, 1'b1, line);
      wait_burst(1'b0, ok);
      serve(1'b0, line, 32'h0000_1060, 1, -1, 0, 4);
      finish_burst(1'b0, 1'b1);
   endtask

   task automatic test_dcache_write();
      logic [S_LINE-1:0] line;
      bit ok;
      line = mk_line(4'hA, 4'hB, 4'hC, 4'hD);
      d_write = 1'b1; d_address = 32'h8000_00A0; d_wdata = line;
      push(1'b1, 1'b0, '0);
      wait_burst(1'b1, ok);
      d_wdata = mk_line(4'h5, 4'h6, 4'h7, 4'h8);   // the latched copy must be the one sent
      serve(1'b1, line, 32'h8000_00A0, 0, -1, 0, 4);
      finish_burst(1'b1, 1'b1);
   endtask

   task automatic test_simultaneous();
      logic [S_LINE-1:0] iline, dline;
      bit ok;
      iline = mk_line(4'h9, 4'h8, 4'h7, 4'h6);
      dline = mk_line(4'hE, 4'hF, 4'h0, 4'h1);
      i_read = 1'b1; i_address = 32'h2000_0040;
      d_read = 1'b1; d_address = 32'h3000_0085;
      push(1'b1, 1'b1, dline);
      push(1'b0, 1'b1, iline);
      wait_burst(1'b0, ok);
      serve(1'b0, dline, 32'h3000_0080, 0, -1, 0, 4);
      finish_burst(1'b1, 1'b1);
      wait_burst(1'b0, ok);
      serve(1'b0, iline, 32'h2000_0040, 2, -1, 0, 4);
      finish_burst(1'b0, 1'b1);
      total++;
      if (order.len() < 2 || order.substr(order.len() - 2, order.len() - 1) != "DI") begin
         bad++;
         $display("FAIL sim_order: got resp order %s wanted ...DI", order);
      end
      total++;
      if (d_rdata !== dline) begin
         bad++;
         $display("FAIL sim_d_hold: got %h wanted %h", d_rdata, dline);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [S_LINE-1:0] line;
      bit ok;
      line = mk_line(4'h3, 4'h5, 4'h7, 4'h9);
      i_read = 1'b1; i_address = 32'h0000_4000;
      push(1'b0, 1'b1, line);
      wait_burst(1'b0, ok);
      serve(1'b0, line, 32'h0000_4000, 0, -1, 0, 2);
      #3 rst = 1'b0;
      #1;
      void'(sb_q.pop_back());
      i_read = 1'b0;
      total++;
      if (pmem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
         bad++;
         $display("FAIL rst_async: got rd=%0b i_resp=%0b i_rdata=%h wanted 0 0 0", pmem_read, i_resp, i_rdata);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (8) @(posedge clk);
      line = mk_line(4'hC, 4'h0, 4'hF, 4'hE);
      #1 i_read = 1'b1; i_address = 32'h0000_403F;
      push(1'b0, 1'b1, line);
      wait_burst(1'b0, ok);
      serve(1'b0, line, 32'h0000_4020, 1, -1, 0, 4);
      finish_burst(1'b0, 1'b1);
   endtask

   task automatic test_stall();
      logic [S_LINE-1:0] line;
      bit ok;
      line = mk_line(4'h2, 4'h4, 4'h6, 4'h8);
      i_read = 1'b1; i_address = 32'h0000_5010;
      push(1'b0, 1'b1, line);
      wait_burst(1'b0, ok);
      serve(1'b0, line, 32'h0000_5000, 0, 2, 50, 4);
      finish_burst(1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [S_LINE-1:0] la, lb;
      bit ok;
      la = mk_line(4'h1, 4'h3, 4'h5, 4'h7);
      lb = mk_line(4'hB, 4'hA, 4'h9, 4'h8);
      i_read = 1'b1; i_address = 32'h0000_6000;
      push(1'b0, 1'b1, la);
      wait_burst(1'b0, ok);
      serve(1'b0, la, 32'h0000_6000, 0, -1, 0, 4);
      i_address = 32'h0000_7000;   // request stays high through DONE: a new request
      push(1'b0, 1'b1, lb);
      finish_burst(1'b0, 1'b0);
      wait_burst(1'b0, ok);
      serve(1'b0, lb, 32'h0000_7000, 0, -1, 0, 4);
      finish_burst(1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_icache_read();
      test_dcache_write();
      test_simultaneous();
      test_reset_mid_burst();
      test_stall();
      test_back_to_back();
      repeat (5) @(posedge clk);
      total++;
      if (sb_q.size() != 0 || n_i_resp != 6 || n_d_resp != 2) begin
         bad++;
         $display("FAIL resp_totals: got pending=%0d i=%0d d=%0d wanted 0 6 2", sb_q.size(), n_i_resp, n_d_resp);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
